// File: rtl/boot_load_ctrl.sv
// boot_load_ctrl: streams a program image from flash BRAM into instruction memory, then releases processor reset.
// Define BOOT_CHECKSUM_EN to verify a trailing additive checksum word and trap mismatches in an error state.
module boot_load_ctrl #(
   parameter int FLASH_AW   = 10,
   parameter int IMEM_AW    = 8,
   parameter int DATA_W     = 16,
   parameter int FLASH_BASE = 0,
   parameter int PROG_WORDS = 256,
   parameter int RST_HOLD   = 4
) (
   input  logic                clk_in,
   input  logic                rst_n,
   input  logic                start,
   input  logic                reload,
   output logic                flash_en,
   output logic [FLASH_AW-1:0] flash_addr,
   input  logic [DATA_W-1:0]   flash_data,
   output logic                imem_we,
   output logic [IMEM_AW-1:0]  imem_addr,
   output logic [DATA_W-1:0]   imem_data,
   output logic                proc_rst,
   output logic                busy,
   output logic                done,
   output logic                error
);
   localparam int CW = IMEM_AW + 1;
   localparam int HW = RST_HOLD > 1 ? $clog2(RST_HOLD) : 1;
   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] LOAD  = 3'd1;
   localparam logic [2:0] DRAIN = 3'd2;
   localparam logic [2:0] HOLD  = 3'd3;
   localparam logic [2:0] RUN   = 3'd4;
`ifdef BOOT_CHECKSUM_EN
   localparam logic [2:0] ERR   = 3'd5;
   logic [DATA_W-1:0] acc;
`endif
   logic [2:0]    state;
   logic [CW-1:0] rd_cnt;
   logic [CW-1:0] wr_cnt;
   logic [HW-1:0] hcnt;
   logic          vld;
   logic          go;
   logic          last_wr;
   always_comb begin
`ifdef BOOT_CHECKSUM_EN
      go = state == IDLE ? start : (state == RUN || state == ERR) ? reload : 1'b0;
`else
      go = state == IDLE ? start : state == RUN ? reload : 1'b0;
`endif
      last_wr = imem_we && imem_addr == IMEM_AW'(PROG_WORDS - 1);
   end
   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         flash_en   <= 1'b0;
         flash_addr <= FLASH_AW'(FLASH_BASE);
         rd_cnt     <= '0;
         wr_cnt     <= '0;
         hcnt       <= '0;
         vld        <= 1'b0;
         imem_we    <= 1'b0;
         imem_addr  <= '0;
         imem_data  <= '0;
         proc_rst   <= 1'b1;
         busy       <= 1'b0;
         done       <= 1'b0;
         error      <= 1'b0;
`ifdef BOOT_CHECKSUM_EN
         acc        <= '0;
`endif
      end else begin
         // Data arrives one cycle after the read, so writes trail reads by the valid flag.
         vld     <= flash_en;
         imem_we <= vld;
         if (vld) begin
            imem_data <= flash_data;
            imem_addr <= wr_cnt[IMEM_AW-1:0];
            wr_cnt    <= wr_cnt + 1'b1;
         end
`ifdef BOOT_CHECKSUM_EN
         if (vld && wr_cnt != CW'(PROG_WORDS - 1))
            acc <= acc + flash_data;
`endif
         if (go) begin
            state      <= LOAD;
            flash_en   <= 1'b1;
            flash_addr <= FLASH_AW'(FLASH_BASE);
            rd_cnt     <= CW'(1);
            wr_cnt     <= '0;
            hcnt       <= '0;
            proc_rst   <= 1'b1;
            busy       <= 1'b1;
            done       <= 1'b0;
            error      <= 1'b0;
`ifdef BOOT_CHECKSUM_EN
            acc        <= '0;
`endif
         end else begin
            case (state)
               LOAD:
                  if (rd_cnt == CW'(PROG_WORDS)) begin
                     flash_en <= 1'b0;
                     state    <= DRAIN;
                  end else begin
                     flash_addr <= flash_addr + 1'b1;
                     rd_cnt     <= rd_cnt + 1'b1;
                  end
               DRAIN:
                  if (last_wr) begin
`ifdef BOOT_CHECKSUM_EN
                     // The final word written is the checksum of all preceding words.
                     if (acc != imem_data) begin
                        state <= ERR;
                        busy  <= 1'b0;
                        error <= 1'b1;
                     end else
                        state <= HOLD;
`else
                     state <= HOLD;
`endif
                  end
               HOLD:
                  if (hcnt == HW'(RST_HOLD - 1)) begin
                     state    <= RUN;
                     proc_rst <= 1'b0;
                     busy     <= 1'b0;
                     done     <= 1'b1;
                  end else
                     hcnt <= hcnt + 1'b1;
               default: ;
            endcase
         end
      end
   end
endmodule
